// File: rtl/eq_arb_pkg.sv
// Shared types and helpers for the equality-check arbiter slice.
package eq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ. Produces one-hot and encoded grant.
module rr_arbiter
  import eq_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_valid_o
);

  logic [IDW:0] cand;

  always_comb begin
    cand        = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr_i < NUM_REQ and i < NUM_REQ, so one subtraction performs the wrap.
      cand = {1'b0, ptr_i} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!gnt_valid_o && req_i[cand[IDW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = cand[IDW-1:0];
      end
    end
    gnt_o = gnt_valid_o ? (NUM_REQ'(1) << gnt_id_o) : '0;
  end

endmodule

// File: rtl/eq_check_arbiter.sv
// Shares one registered x==y compare unit among NUM_REQ requesters using
// round-robin arbitration, with a backpressured response and mismatch counter.
module eq_check_arbiter
  import eq_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned IDW     = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ-1:0]        req_use_dflt,
  input  logic [DATA_W-1:0]         dflt_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_eq,
  output logic [CNT_W-1:0]          mismatch_cnt,
  output logic                      busy
);

  state_e             state_q;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id_q, rsp_id_q;
  logic [DATA_W-1:0]  x_q, y_q, x_sel, y_sel;
  logic               rsp_valid_q, rsp_eq_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        x_sel = req_x[i*DATA_W +: DATA_W];
        y_sel = req_use_dflt[i] ? dflt_y : req_y[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = (rsp_id_q == IDW'(NUM_REQ-1)) ? '0 : rsp_id_q + 1'b1;
  assign cnt_d = (rsp_eq_q || (&cnt_q)) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      rsp_id_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_eq_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_valid) begin
          x_q      <= x_sel;
          y_q      <= y_sel;
          gnt_id_q <= gnt_id;
          state_q  <= CMP;
        end
        CMP: begin
          rsp_eq_q    <= (x_q == y_q);
          rsp_id_q    <= gnt_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          ptr_q       <= ptr_d;
          cnt_q       <= cnt_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is only offered in IDLE; gated by rst_n so it reads 0 during reset.
  assign req_ready    = (rst_n && (state_q == IDLE)) ? gnt : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_eq       = rsp_eq_q;
  assign mismatch_cnt = cnt_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/eq_check_arbiter.md
Name: eq_check_arbiter

Overview:
- Shares one registered equality-compare unit (x == y, with optional default y) among NUM_REQ requesters.
- Round-robin arbitration; valid/ready on every requester port; a single response channel with backpressure.
- Sits between assertion-style check sources and the result/monitor path.
- Also keeps a saturating mismatch counter for status readout.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, operand width.
- CNT_W, 16, mismatch counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; a request transfers when valid && ready.
- req_x  in  NUM_REQ*DATA_W  packed x operands; requester i uses bits [i*DATA_W +: DATA_W].
- req_y  in  NUM_REQ*DATA_W  packed y operands.
- req_use_dflt  in  NUM_REQ  1 = replace y with dflt_y.
- dflt_y  in  DATA_W  shared default y; sampled at accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- rsp_eq  out  1  compare result.
- mismatch_cnt  out  CNT_W  count of delivered responses with rsp_eq = 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; RR pointer = 0.
  - All outputs 0: rsp_valid, rsp_id, rsp_eq, mismatch_cnt, busy, req_ready.
  - Operand registers cleared.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any req_valid, the grant goes to the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in that cycle only; no other ready bit is high.
  - Capture x, plus y or dflt_y (selected by req_use_dflt[grant]), and the grant index. Next state = CMP.
  - With no valid requests, stay in IDLE; req_ready = 0.
- CMP: register eq = (x_q == y_q) and id. Next state = RESP. req_ready = 0.
- RESP:
  - rsp_valid = 1. rsp_id and rsp_eq are stable until the handshake.
  - On rsp_ready: go to IDLE; ptr = (id + 1) mod NUM_REQ; if eq == 0, mismatch_cnt += 1, saturating at all-ones.
  - Without rsp_ready: hold in RESP.
- Latency: accept at edge t; rsp_valid high from cycle t+2. Minimum 3 cycles per transaction.
- req_ready is 0 in CMP and RESP. Requesters must hold valid and operands until accepted. Dropping valid before accept is legal; that request is simply not served.
- Fairness: a requester that holds valid is served within NUM_REQ transactions.
- Simultaneous events: with all requesters valid, the grant order is ptr, ptr+1, ... ptr+NUM_REQ-1.
- rsp_ready while not in RESP is ignored.
- Reset mid-transaction discards the in-flight compare; no response and no count update follow.
- mismatch_cnt never wraps; once saturated it holds until reset.
- Equality is a full DATA_W-bit compare. Any X/Z on operands is outside the defined behaviour; the bench drives only known values.

Decomposition:
- Package eq_arb_pkg:
  - state_e enum (IDLE, CMP, RESP), 2 bits.
  - Localparam function for the id width: clog2 with a minimum of 1.
- Sub-module rr_arbiter:
  - Combinational one-hot grant and encoded index from req and ptr.
  - Parameterised by NUM_REQ.
  - Reused by other shared-resource blocks.
- Top module holds the FSM, operand registers, pointer and counter.

Test Plan:
- Single request: requester 2 with x=8'h5A, y=8'h5A, use_dflt=0 -> req_ready[2] in cycle 0, rsp_valid at cycle 2, rsp_id=2, rsp_eq=1, mismatch_cnt=0.
- Default operand: requester 1 with x=8'h33, y=8'hFF, use_dflt=1, dflt_y=8'h33 -> rsp_eq=1. Repeat with dflt_y=8'h34 -> rsp_eq=0, mismatch_cnt=1.
- Round-robin: all four valid continuously, rsp_ready=1 -> rsp_id order 0,1,2,3,0. Each grant is spaced 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_eq stable, all req_ready=0, counter unchanged. Release -> one count update only.
- Saturation: CNT_W=4, 17 mismatching responses -> mismatch_cnt reaches 4'hF and stays there.
- Async reset: assert rst_n low in CMP, between clock edges -> outputs go to 0 immediately. After release, no stale response appears and the next grant starts from requester 0.
